// File: rtl/clk_pkg.sv
//==============================================================================
// Module : clk_pkg
// Brief  : Types, moduli and helpers for the HH:MM:SS BCD timekeeper.
//          Includes the edit-mode enum, BCD digit types, seconds/minutes
//          moduli, and a binary-to-two-digit-BCD helper used to build
//          reset values and terminal counts at elaboration.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

package clk_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SET_HR  = 2'd1,
    SET_MIN = 2'd2
  } mode_e;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam int SEC_MOD = 60;
  localparam int MIN_MOD = 60;

  // Binary 0..99 to packed two-digit BCD.
  function automatic bcd2_t to_bcd2(input int unsigned v);
    bcd2_t r;
    r.tens = 4'(v / 10);
    r.ones = 4'(v % 10);
    return r;
  endfunction

endpackage : clk_pkg

`default_nettype wire

// File: rtl/bcd2_mod_counter.sv
//==============================================================================
// Module : bcd2_mod_counter
// Brief  : Two-digit BCD modulo counter (0..MOD-1) with increment and clear.
// Ports  : clk   in   system clock
//          rst   in   synchronous active-high reset, loads BCD(INIT)
//          inc   in   advance by one (ones 9->0 carries into tens)
//          clr   in   force 00; takes priority over inc for the register
//          q     out  registered count {tens, ones}
//          wrap  out  combinational: inc while at MOD-1
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module bcd2_mod_counter
  import clk_pkg::*;
#(
  parameter int MOD  = 60,
  parameter int INIT = 0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  clr,
  output bcd2_t q,
  output logic  wrap
);

  localparam bcd2_t C_LAST_BCD = to_bcd2(MOD - 1);
  localparam bcd2_t C_INIT_BCD = to_bcd2(INIT);

  generate
    if (MOD < 2 || MOD > 100 || INIT < 0 || INIT >= MOD) begin : g_bad_param
      $error("bcd2_mod_counter: illegal MOD/INIT");
    end
  endgenerate

  bcd2_t cnt_q;
  bcd2_t cnt_d;
  logic  w_at_last;

  assign w_at_last = (cnt_q == C_LAST_BCD);
  // The carry is taken from inc even when clr also fires, so a clear on
  // the same cycle as a roll-over still propagates the carry upstream.
  assign wrap      = inc & w_at_last;
  assign q         = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      if (w_at_last) begin
        cnt_d = '0;
      end else if (cnt_q.ones == 4'd9) begin
        cnt_d.ones = 4'd0;
        cnt_d.tens = cnt_q.tens + 4'd1;
      end else begin
        cnt_d.ones = cnt_q.ones + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= C_INIT_BCD;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : bcd2_mod_counter

`default_nettype wire

// File: rtl/bcd_time_counter.sv
//==============================================================================
// Module : bcd_time_counter
// Brief  : HH:MM:SS BCD timekeeper with run / set-hours / set-minutes modes.
//          Counts 1 Hz ticks in RUN; in the set modes the inc pulse bumps
//          the selected field without carry and seconds are held at 00.
// Ports  : clk         in   system clock
//          rst         in   synchronous active-high reset
//          tick_i      in   1 Hz enable, one cycle wide
//          mode_i      in   pulse: advance edit mode
//          inc_i       in   pulse: increment field being edited
//          sec_o       out  BCD seconds {tens, ones}
//          min_o       out  BCD minutes {tens, ones}
//          hr_o        out  BCD hours   {tens, ones}
//          mode_o      out  0=RUN 1=SET_HR 2=SET_MIN
//          day_wrap_o  out  one-cycle pulse on wrap to 00:00:00
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module bcd_time_counter
  import clk_pkg::*;
#(
  parameter int MAX_HOURS    = 24,
  parameter int INIT_HOURS   = 0,
  parameter int INIT_MINUTES = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       mode_i,
  input  logic       inc_i,
  output logic [7:0] sec_o,
  output logic [7:0] min_o,
  output logic [7:0] hr_o,
  output logic [1:0] mode_o,
  output logic       day_wrap_o
);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_SET_HR  = SET_HR;
  localparam logic [1:0] ST_SET_MIN = SET_MIN;

  generate
    if (MAX_HOURS != 12 && MAX_HOURS != 24) begin : g_bad_max_hours
      $error("bcd_time_counter: MAX_HOURS must be 12 or 24");
    end
    if (INIT_HOURS < 0 || INIT_HOURS >= MAX_HOURS) begin : g_bad_init_hours
      $error("bcd_time_counter: INIT_HOURS out of range");
    end
    if (INIT_MINUTES < 0 || INIT_MINUTES >= MIN_MOD) begin : g_bad_init_minutes
      $error("bcd_time_counter: INIT_MINUTES out of range");
    end
  endgenerate

  logic [1:0] mode_q;
  logic [1:0] mode_d;
  logic       day_wrap_q;
  logic       day_wrap_d;

  logic  w_run;
  logic  w_set_hr;
  logic  w_set_min;
  logic  w_edit_inc;
  logic  w_sec_inc;
  logic  w_sec_clr;
  logic  w_min_inc;
  logic  w_hr_inc;
  logic  w_sec_wrap;
  logic  w_min_wrap;
  logic  w_hr_wrap;
  bcd2_t w_sec;
  bcd2_t w_min;
  bcd2_t w_hr;

  assign w_run     = (mode_q == ST_RUN);
  assign w_set_hr  = (mode_q == ST_SET_HR);
  assign w_set_min = (mode_q == ST_SET_MIN);

  // A mode pulse in the same cycle as inc wins; the edit is dropped.
  assign w_edit_inc = inc_i & ~mode_i;

  // Seconds are cleared whenever not running, and on the RUN->SET_HR cycle
  // after the tick (and its carries) has been applied.
  assign w_sec_inc = w_run & tick_i;
  assign w_sec_clr = ~w_run | mode_i;

  // Carries only chain in RUN; edits never ripple into the next field.
  assign w_min_inc = (w_run & w_sec_wrap) | (w_set_min & w_edit_inc);
  assign w_hr_inc  = (w_run & w_min_wrap) | (w_set_hr  & w_edit_inc);

  // In RUN an hours roll-over can only come from a full seconds/minutes
  // carry chain, so this is exactly the 23:59:59 -> 00:00:00 step.
  assign day_wrap_d = w_run & w_hr_wrap;

  always_comb begin
    mode_d = mode_q;
    if (mode_i) begin
      case (mode_q)
        ST_RUN:     mode_d = ST_SET_HR;
        ST_SET_HR:  mode_d = ST_SET_MIN;
        ST_SET_MIN: mode_d = ST_RUN;
        default:    mode_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= ST_RUN;
      day_wrap_q <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  bcd2_mod_counter #(
    .MOD  (SEC_MOD),
    .INIT (0)
  ) u_sec (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_sec_inc),
    .clr  (w_sec_clr),
    .q    (w_sec),
    .wrap (w_sec_wrap)
  );

  bcd2_mod_counter #(
    .MOD  (MIN_MOD),
    .INIT (INIT_MINUTES)
  ) u_min (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_min_inc),
    .clr  (1'b0),
    .q    (w_min),
    .wrap (w_min_wrap)
  );

  bcd2_mod_counter #(
    .MOD  (MAX_HOURS),
    .INIT (INIT_HOURS)
  ) u_hr (
    .clk  (clk),
    .rst  (rst),
    .inc  (w_hr_inc),
    .clr  (1'b0),
    .q    (w_hr),
    .wrap (w_hr_wrap)
  );

  assign sec_o      = w_sec;
  assign min_o      = w_min;
  assign hr_o       = w_hr;
  assign mode_o     = mode_q;
  assign day_wrap_o = day_wrap_q;

endmodule : bcd_time_counter

`default_nettype wire
